// File: rtl/ts_chs_pkg.sv
// ts_chs_pkg: shared default widths and the completion record carried through the arbiter.
package ts_chs_pkg;
    localparam int TS_NUM_PORTS = 8;
    localparam int TS_ID_WIDTH = 20;
    localparam int TS_DATA_WIDTH = 96;
    localparam int TS_DEPTH = 4;
    localparam int TS_DROP_CNTR_WIDTH = 16;
    typedef struct packed {
        logic [TS_ID_WIDTH-1:0]   fp;
        logic [TS_DATA_WIDTH-1:0] data;
    } ts_resp_t;
endpackage

// File: rtl/ts_resp_fifo.sv
// ts_resp_fifo: single-clock FIFO; a push on full is accepted when the same cycle pops.
module ts_resp_fifo
    import ts_chs_pkg::*;
#(
    parameter int WIDTH = TS_ID_WIDTH + TS_DATA_WIDTH,
    parameter int DEPTH = TS_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic do_push, do_pop;
    assign o_empty = wr_q == rd_q;
    assign o_full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign o_rdata = mem_q[rd_q[AW-1:0]];
    always_comb begin
        do_pop = i_pop && !o_empty;
        do_push = i_push && (!o_full || do_pop);
        mem_d = mem_q;
        if (do_push) mem_d[wr_q[AW-1:0]] = i_wdata;
        wr_d = wr_q + (AW+1)'(do_push);
        rd_d = rd_q + (AW+1)'(do_pop);
    end
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end
endmodule

// File: rtl/ts_resp_arb.sv
// ts_resp_arb: merges per-port timestamp completions through per-port FIFOs into one
// registered output stream using round-robin arbitration, with per-port drop statistics.
module ts_resp_arb
    import ts_chs_pkg::*;
#(
    parameter int NUM_PORTS = TS_NUM_PORTS,
    parameter int ID_WIDTH = TS_ID_WIDTH,
    parameter int DATA_WIDTH = TS_DATA_WIDTH,
    parameter int DEPTH = TS_DEPTH,
    parameter int DROP_CNTR_WIDTH = TS_DROP_CNTR_WIDTH,
    localparam int CHANNEL_WIDTH = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                                 i_ts_req_clk,
    input  logic                                 i_ts_req_rst,
    input  logic [NUM_PORTS-1:0]                 i_ts_valid,
    input  logic [NUM_PORTS*ID_WIDTH-1:0]        i_ts_fp,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]      i_ts_data,
    output logic                                 o_valid,
    input  logic                                 i_ready,
    output logic [CHANNEL_WIDTH-1:0]             o_channel,
    output logic [ID_WIDTH-1:0]                  o_fp,
    output logic [DATA_WIDTH-1:0]                o_data,
    input  logic                                 i_clr_stats,
    output logic [NUM_PORTS-1:0]                 o_overflow,
    output logic [NUM_PORTS*DROP_CNTR_WIDTH-1:0] o_drop_cnt
);
    localparam int RW = ID_WIDTH + DATA_WIDTH;
    localparam int DC = DROP_CNTR_WIDTH;
    logic [NUM_PORTS-1:0] full, empty, pop, req, mask_hi, drop;
    logic [RW-1:0] rdata [NUM_PORTS];
    logic [2*NUM_PORTS-1:0] dbl;
    logic [CHANNEL_WIDTH-1:0] gnt, last_q, last_d, ch_q, ch_d;
    logic grant, ld, valid_q, valid_d;
    logic [ID_WIDTH-1:0] fp_q, fp_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [NUM_PORTS-1:0] ovf_q, ovf_d;
    logic [NUM_PORTS*DC-1:0] cnt_q, cnt_d;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        ts_resp_fifo #(.WIDTH(RW), .DEPTH(DEPTH)) u_fifo (
            .clk     (i_ts_req_clk),
            .rst     (i_ts_req_rst),
            .i_push  (i_ts_valid[p]),
            .i_pop   (pop[p]),
            .i_wdata ({i_ts_fp[p*ID_WIDTH +: ID_WIDTH], i_ts_data[p*DATA_WIDTH +: DATA_WIDTH]}),
            .o_rdata (rdata[p]),
            .o_full  (full[p]),
            .o_empty (empty[p])
        );
        assign drop[p] = i_ts_valid[p] && full[p] && !pop[p];
    end

    // Upper copy holds all requests, lower copy only those above last_grant; the lowest set bit wins.
    always_comb begin
        req = ~empty;
        ld = !valid_q || i_ready;
        grant = ld && (|req);
        for (int p = 0; p < NUM_PORTS; p++) mask_hi[p] = p > int'(last_q);
        dbl = {req, req & mask_hi};
        gnt = '0;
        for (int i = 2*NUM_PORTS-1; i >= 0; i--)
            if (dbl[i]) gnt = CHANNEL_WIDTH'(i >= NUM_PORTS ? i - NUM_PORTS : i);
        pop = grant ? NUM_PORTS'(1) << gnt : '0;
        last_d = grant ? gnt : last_q;
        valid_d = ld ? grant : valid_q;
        ch_d = grant ? gnt : ch_q;
        {fp_d, data_d} = grant ? rdata[gnt] : {fp_q, data_q};
        for (int p = 0; p < NUM_PORTS; p++) begin
            ovf_d[p] = !i_clr_stats && (ovf_q[p] || drop[p]);
            cnt_d[p*DC +: DC] = i_clr_stats ? '0 :
                cnt_q[p*DC +: DC] + DC'(drop[p] && !(&cnt_q[p*DC +: DC]));
        end
    end

    always_ff @(posedge i_ts_req_clk) begin
        if (i_ts_req_rst) begin
            valid_q <= 1'b0;
            ch_q <= '0;
            fp_q <= '0;
            data_q <= '0;
            last_q <= CHANNEL_WIDTH'(NUM_PORTS-1);
            ovf_q <= '0;
            cnt_q <= '0;
        end else begin
            valid_q <= valid_d;
            ch_q <= ch_d;
            fp_q <= fp_d;
            data_q <= data_d;
            last_q <= last_d;
            ovf_q <= ovf_d;
            cnt_q <= cnt_d;
        end
    end

    assign o_valid = valid_q;
    assign o_channel = ch_q;
    assign o_fp = fp_q;
    assign o_data = data_q;
    assign o_overflow = ovf_q;
    assign o_drop_cnt = cnt_q;
endmodule

// File: doc/ts_resp_arb.md
TS_RESP_ARB -- requirements
Module: ts_resp_arb

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 8: number of per-port timestamp completion sources.
REQ-002 SHALL have parameter ID_WIDTH, default 20: timestamp fingerprint/ID width.
REQ-003 SHALL have parameter DATA_WIDTH, default 96: timestamp data width.
REQ-004 SHALL have parameter DEPTH, default 4 (power of two, >=2): per-port buffer entries.
REQ-005 SHALL have parameter DROP_CNTR_WIDTH, default 16: per-port drop counter width.
REQ-006 SHALL have derived parameter CHANNEL_WIDTH = max(1, $clog2(NUM_PORTS)).
REQ-007 SHALL have port i_ts_req_clk  in  1: the single clock; synchronous, active-high reset is fixed.
REQ-008 SHALL have port i_ts_req_rst  in  1: synchronous active-high reset.
REQ-009 SHALL have port i_ts_valid  in  NUM_PORTS: per-port completion strobe, no backpressure.
REQ-010 SHALL have port i_ts_fp  in  NUM_PORTS*ID_WIDTH: per-port completion ID, port p at slice p.
REQ-011 SHALL have port i_ts_data  in  NUM_PORTS*DATA_WIDTH: per-port timestamp.
REQ-012 SHALL have port o_valid  out  1: merged completion valid.
REQ-013 SHALL have port i_ready  in  1: downstream accept.
REQ-014 SHALL have port o_channel  out  CHANNEL_WIDTH: source port of the current output.
REQ-015 SHALL have port o_fp  out  ID_WIDTH: completion ID.
REQ-016 SHALL have port o_data  out  DATA_WIDTH: timestamp.
REQ-017 SHALL have port i_clr_stats  in  1: clears drop counters and overflow flags.
REQ-018 SHALL have port o_overflow  out  NUM_PORTS: sticky per-port drop flag.
REQ-019 SHALL have port o_drop_cnt  out  NUM_PORTS*DROP_CNTR_WIDTH: per-port saturating drop count.

Function
REQ-020 SHALL write {i_ts_fp[p], i_ts_data[p]} into port p's FIFO on each cycle where i_ts_valid[p]=1 and the FIFO is not full after any same-cycle pop.
REQ-021 SHALL accept the write when FIFO p is full and popped in the same cycle (no drop).
REQ-022 SHALL discard the completion when FIFO p is full and not popped, set o_overflow[p], and increment o_drop_cnt[p], saturating at all-ones.
REQ-023 SHALL keep the output register loadable when o_valid=0, or when o_valid=1 and i_ready=1.
REQ-024 SHALL, when the output register is loadable, grant the first non-empty FIFO searching round-robin from (last_grant+1) mod NUM_PORTS, pop it, and load o_channel/o_fp/o_data in that cycle.
REQ-025 SHALL set last_grant to the granted port only on a grant; it resets to NUM_PORTS-1 so port 0 has first priority.
REQ-026 SHALL hold o_valid, o_channel, o_fp and o_data stable while o_valid=1 and i_ready=0.
REQ-027 SHALL clear o_valid when loadable and all FIFOs are empty.
REQ-028 SHALL provide a latency of 2 cycles with all FIFOs empty and the output idle: i_ts_valid at edge k -> FIFO write at k, output register load at k+1, o_valid=1 after k+1.
REQ-029 SHALL sustain 1 completion/cycle with i_ready held high.
REQ-030 SHALL preserve per-port order; inter-port order is arbitration order only.
REQ-031 SHALL give i_clr_stats priority over a same-cycle drop: counter=0, flag=0.

Reset
REQ-032 SHALL, on reset, empty all FIFOs and clear o_valid, o_channel, o_fp, o_data, o_overflow and o_drop_cnt to 0, with last_grant=NUM_PORTS-1.
REQ-033 SHALL lose any in-flight completion or held output on reset mid-operation, without a spurious o_valid on the cycle after reset.
REQ-034 SHALL ignore i_ts_valid during reset.

Structure
REQ-035 SHALL place the default widths and a ts_resp_t struct {fp, data} in the shared package ts_chs_pkg.
REQ-036 SHALL instantiate one sub-module per port, ts_resp_fifo: single-clock, DEPTH-entry, with full/empty, push/pop and the same-cycle push-on-full-with-pop rule.
REQ-037 SHALL implement the round-robin grant in ts_resp_arb as a double-width mask/priority search with no combinational path from i_ready to FIFO data other than the pop enable.

Verification
REQ-038 SHALL cover: single pulse on port 3 (fp=0x00005, data=0xABC) with i_ready=1 -> o_valid two cycles later, o_channel=3, o_fp=0x00005, o_data=0xABC, for one cycle.
REQ-039 SHALL cover: ports 0, 2 and 7 pulse in the same cycle, with i_ready=1 -> outputs on consecutive cycles in channel order 0, 2, 7.
REQ-040 SHALL cover: i_ready=0 with port 1 pulsing 6 times (DEPTH=4) -> o_overflow[1]=1, o_drop_cnt[1]=1, outputs held stable; after release, 5 outputs in order (1 in register + 4).
REQ-041 SHALL cover: port 5 full with i_ready=1 and a new pulse on the pop cycle -> no drop, o_drop_cnt[5] unchanged.
REQ-042 SHALL cover: all 8 ports continuously valid with i_ready=1 -> grants rotate 0..7 repeatedly, each port 1 per 8 cycles.
REQ-043 SHALL cover: reset asserted while o_valid=1 and FIFOs non-empty -> after reset o_valid=0 and no stale outputs; i_clr_stats together with a drop -> counter=0.
